fetch_unit: RTL and testbench



---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: hazard controls, redirect target, instruction-memory read port and IF/ID outputs.
interface fetch_unit_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 16
);
  logic               stall;
  logic               flush;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] if_instr;
  logic [INSTR_W-1:0] if_imm;
  logic [PC_W-1:0]    if_pc;
  logic               if_valid;
  logic               busy_boot;

  modport master (
    input  stall, flush, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, if_instr, if_imm, if_pc, if_valid, busy_boot
  );

  modport slave (
    output stall, flush, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, if_instr, if_imm, if_pc, if_valid, busy_boot
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch into IF/ID: 1 cycle for plain words, 2 (one bubble) for LDM + immediate; stall freezes everything.
// Define BOOT_VECTOR_EN to load the start PC from memory words 0 (high half) and 1 (low half) after reset.
module fetch_unit #(
  parameter int              PC_W       = 32,
  parameter int              INSTR_W    = 16,
  parameter int              OPC_W      = 5,
  parameter logic [OPC_W-1:0] IMM_OPCODE = 5'b10010,
  parameter logic [PC_W-1:0]  RESET_PC   = 32
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {BOOT_HI, BOOT_LO, FETCH, FETCH_IMM} state_t;

  state_t             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic [PC_W-1:0]    hold_pc_q;
  logic [PC_W-1:0]    if_pc_q;
  logic [INSTR_W-1:0] hold_q;
  logic [INSTR_W-1:0] if_instr_q;
  logic [INSTR_W-1:0] if_imm_q;
  logic               if_valid_q;
  logic               is_imm;

  assign pc_d   = pc_q + PC_W'(1);
  assign is_imm = (bus.imem_rdata[INSTR_W-1 -: OPC_W] == IMM_OPCODE);

  assign bus.if_instr = if_instr_q;
  assign bus.if_imm   = if_imm_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_valid = if_valid_q;

`ifdef BOOT_VECTOR_EN
  logic busy_boot_q;

  assign bus.busy_boot = busy_boot_q;

  always_comb begin
    case (state_q)
      BOOT_HI: bus.imem_addr = '0;
      BOOT_LO: bus.imem_addr = PC_W'(1);
      default: bus.imem_addr = pc_q;
    endcase
  end
`else
  assign bus.busy_boot = 1'b0;
  assign bus.imem_addr = pc_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_instr_q <= '0;
      if_imm_q   <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      hold_q     <= '0;
      hold_pc_q  <= '0;
`ifdef BOOT_VECTOR_EN
      pc_q        <= '0;
      state_q     <= BOOT_HI;
      busy_boot_q <= 1'b1;
`else
      pc_q    <= RESET_PC;
      state_q <= FETCH;
`endif
    end else begin
      case (state_q)
`ifdef BOOT_VECTOR_EN
        BOOT_HI: begin
          pc_q[PC_W-1:INSTR_W] <= bus.imem_rdata;
          state_q              <= BOOT_LO;
        end
        BOOT_LO: begin
          pc_q[INSTR_W-1:0] <= bus.imem_rdata;
          state_q           <= FETCH;
          busy_boot_q       <= 1'b0;
        end
`endif
        default: begin
          if (bus.redirect_valid) begin
            // A half-fetched LDM is dropped; the hold register is simply overwritten later.
            pc_q       <= bus.redirect_pc;
            state_q    <= FETCH;
            if_valid_q <= 1'b0;
          end else if (bus.flush || !bus.stall) begin
            pc_q <= pc_d;
            if (state_q == FETCH_IMM) begin
              if_instr_q <= hold_q;
              if_imm_q   <= bus.imem_rdata;
              if_pc_q    <= hold_pc_q;
              if_valid_q <= !bus.flush;
              state_q    <= FETCH;
            end else if (is_imm) begin
              hold_q     <= bus.imem_rdata;
              hold_pc_q  <= pc_q;
              if_valid_q <= 1'b0;
              state_q    <= FETCH_IMM;
            end else begin
              if_instr_q <= bus.imem_rdata;
              if_imm_q   <= '0;
              if_pc_q    <= pc_q;
              if_valid_q <= !bus.flush;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus a randomized stall/redirect run checked against an instruction-stream model.
module tb_fetch_unit;
  localparam logic [4:0]  IMM_OPC  = 5'b10010;
  localparam logic [31:0] START_PC = 32'h20;
`ifdef BOOT_VECTOR_EN
  localparam bit BOOT = 1'b1;
`else
  localparam bit BOOT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] mem [256];
  int n_checks = 0;
  int n_fail = 0;

  fetch_unit_if #(.PC_W(32), .INSTR_W(16)) bus ();

  fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  assign bus.imem_rdata = mem[bus.imem_addr[7:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid} !== 65'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got instr=%h imm=%h pc=%h v=%b expected all zero", bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid);
    end
    n_checks++;
    if (bus.busy_boot !== BOOT) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected %b", bus.busy_boot, BOOT);
    end
    n_checks++;
    if (bus.imem_addr !== (BOOT ? 32'h0 : START_PC)) begin
      n_fail++;
      $display("FAIL reset_addr: got %h expected %h", bus.imem_addr, BOOT ? 32'h0 : START_PC);
    end
    tick();
    reset = 1'b0;
    if (BOOT) begin
      tick();
      n_checks++;
      if ({bus.busy_boot, bus.imem_addr, bus.if_valid} !== {1'b1, 32'h1, 1'b0}) begin
        n_fail++;
        $display("FAIL boot_lo: got busy=%b addr=%h v=%b expected busy=1 addr=1 v=0", bus.busy_boot, bus.imem_addr, bus.if_valid);
      end
      tick();
    end
    n_checks++;
    if ({bus.busy_boot, bus.imem_addr, bus.if_valid} !== {1'b0, START_PC, 1'b0}) begin
      n_fail++;
      $display("FAIL boot_done: got busy=%b addr=%h v=%b expected busy=0 addr=%h v=0", bus.busy_boot, bus.imem_addr, bus.if_valid, START_PC);
    end
  endtask

  task automatic test_imm_fetch();
    tick();
    n_checks++;
    if ({bus.if_valid, bus.imem_addr} !== {1'b0, 32'h21}) begin
      n_fail++;
      $display("FAIL imm_bubble: got v=%b addr=%h expected v=0 addr=00000021", bus.if_valid, bus.imem_addr);
    end
    tick();
    n_checks++;
    if ({bus.if_valid, bus.if_instr, bus.if_imm, bus.if_pc} !== {1'b1, 16'h90A0, 16'h1234, 32'h20}) begin
      n_fail++;
      $display("FAIL imm_deliver: got v=%b instr=%h imm=%h pc=%h expected v=1 instr=90a0 imm=1234 pc=00000020", bus.if_valid, bus.if_instr, bus.if_imm, bus.if_pc);
    end
    tick();
    n_checks++;
    if ({bus.if_valid, bus.if_instr, bus.if_imm, bus.if_pc} !== {1'b1, 16'h0800, 16'h0, 32'h22}) begin
      n_fail++;
      $display("FAIL plain_after_imm: got v=%b instr=%h imm=%h pc=%h expected v=1 instr=0800 imm=0 pc=00000022", bus.if_valid, bus.if_instr, bus.if_imm, bus.if_pc);
    end
  endtask

  task automatic test_stall();
    logic [64:0] snap;
    snap = {bus.if_valid, bus.if_instr, bus.if_imm, bus.if_pc};
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus.if_valid, bus.if_instr, bus.if_imm, bus.if_pc, bus.imem_addr} !== {snap, 32'h23}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h addr=%h expected %h addr=00000023", i, {bus.if_valid, bus.if_instr, bus.if_imm, bus.if_pc}, bus.imem_addr, snap);
      end
    end
    bus.stall = 1'b0;
    tick();
    n_checks++;
    if ({bus.if_valid, bus.if_instr, bus.if_pc} !== {1'b1, 16'h0801, 32'h23}) begin
      n_fail++;
      $display("FAIL stall_resume: got v=%b instr=%h pc=%h expected v=1 instr=0801 pc=00000023", bus.if_valid, bus.if_instr, bus.if_pc);
    end
  endtask

  task automatic test_redirect_imm();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h30;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    n_checks++;
    if ({bus.if_valid, bus.imem_addr} !== {1'b0, 32'h31}) begin
      n_fail++;
      $display("FAIL redir_ldm_start: got v=%b addr=%h expected v=0 addr=00000031", bus.if_valid, bus.imem_addr);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    bus.stall = 1'b1;
    tick();
    n_checks++;
    if ({bus.if_valid, bus.imem_addr} !== {1'b0, 32'h40}) begin
      n_fail++;
      $display("FAIL redir_in_imm: got v=%b addr=%h expected v=0 addr=00000040", bus.if_valid, bus.imem_addr);
    end
    clear_inputs();
    tick();
    n_checks++;
    if ({bus.if_valid, bus.if_instr, bus.if_imm, bus.if_pc} !== {1'b1, 16'h0840, 16'h0, 32'h40}) begin
      n_fail++;
      $display("FAIL redir_target: got v=%b instr=%h imm=%h pc=%h expected v=1 instr=0840 imm=0 pc=00000040", bus.if_valid, bus.if_instr, bus.if_imm, bus.if_pc);
    end
  endtask

  task automatic test_flush();
    bus.flush = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h50;
    tick();
    n_checks++;
    if ({bus.if_valid, bus.imem_addr} !== {1'b0, 32'h50}) begin
      n_fail++;
      $display("FAIL flush_redir: got v=%b addr=%h expected v=0 addr=00000050", bus.if_valid, bus.imem_addr);
    end
    clear_inputs();
    tick();
    n_checks++;
    if ({bus.if_valid, bus.if_instr, bus.if_pc} !== {1'b1, 16'h0850, 32'h50}) begin
      n_fail++;
      $display("FAIL flush_redir_next: got v=%b instr=%h pc=%h expected v=1 instr=0850 pc=00000050", bus.if_valid, bus.if_instr, bus.if_pc);
    end
    for (int k = 0; k < 2; k++) begin
      bus.flush = 1'b1;
      bus.stall = (k == 1);
      tick();
      n_checks++;
      if ({bus.if_valid, bus.imem_addr} !== {1'b0, 32'h52 + 32'(2 * k)}) begin
        n_fail++;
        $display("FAIL flush_only[%0d]: got v=%b addr=%h expected v=0 addr=%h", k, bus.if_valid, bus.imem_addr, 32'h52 + 32'(2 * k));
      end
      clear_inputs();
      tick();
      n_checks++;
      if ({bus.if_valid, bus.if_instr, bus.if_pc} !== {1'b1, 16'h0852 + 16'(2 * k), 32'h52 + 32'(2 * k)}) begin
        n_fail++;
        $display("FAIL flush_recover[%0d]: got v=%b instr=%h pc=%h", k, bus.if_valid, bus.if_instr, bus.if_pc);
      end
    end
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFF;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    n_checks++;
    if ({bus.if_valid, bus.if_instr, bus.if_pc, bus.imem_addr} !== {1'b1, 16'h0123, 32'hFFFF_FFFF, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_top: got v=%b instr=%h pc=%h addr=%h expected v=1 instr=0123 pc=ffffffff addr=00000000", bus.if_valid, bus.if_instr, bus.if_pc, bus.imem_addr);
    end
    tick();
    n_checks++;
    if ({bus.if_valid, bus.if_pc} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_zero: got v=%b pc=%h expected v=1 pc=00000000", bus.if_valid, bus.if_pc);
    end
  endtask

  task automatic test_reset_mid();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h2F;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({bus.if_valid, bus.if_pc, bus.imem_addr} !== {1'b0, 32'h2F, 32'h31}) begin
      n_fail++;
      $display("FAIL pre_reset_imm: got v=%b pc=%h addr=%h expected v=0 pc=0000002f addr=00000031", bus.if_valid, bus.if_pc, bus.imem_addr);
    end
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid, bus.busy_boot, bus.imem_addr} !== {65'd0, BOOT, BOOT ? 32'h0 : START_PC}) begin
      n_fail++;
      $display("FAIL async_reset: got instr=%h imm=%h pc=%h v=%b busy=%b addr=%h", bus.if_instr, bus.if_imm, bus.if_pc, bus.if_valid, bus.busy_boot, bus.imem_addr);
    end
    tick();
    reset = 1'b0;
    if (BOOT) begin
      tick();
      tick();
    end
    tick();
    tick();
    n_checks++;
    if ({bus.if_valid, bus.if_instr, bus.if_pc} !== {1'b1, 16'h90A0, 32'h20}) begin
      n_fail++;
      $display("FAIL restart_after_reset: got v=%b instr=%h pc=%h expected v=1 instr=90a0 pc=00000020", bus.if_valid, bus.if_instr, bus.if_pc);
    end
  endtask

  // Model: the program is a stream of instructions starting at mpc, each one or two words long.
  task automatic test_random();
    logic [31:0] mpc, tgt;
    logic [15:0] ei, eimm;
    logic [64:0] prev;
    bit bubble_seen, st, rv;
    for (int a = 8'h60; a < 256; a++)
      mem[a] = ($urandom_range(0, 3) == 0) ? {IMM_OPC, 11'($urandom)} : 16'($urandom);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h60;
    tick();
    mpc = 32'h60;
    bubble_seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      st = ($urandom_range(0, 3) == 0);
      rv = (mpc >= 32'hF0) || ($urandom_range(0, 19) == 0);
      tgt = 32'h60 + 32'($urandom_range(0, 127));
      bus.stall = st;
      bus.redirect_valid = rv;
      bus.redirect_pc = tgt;
      prev = {bus.if_valid, bus.if_instr, bus.if_imm, bus.if_pc};
      tick();
      n_checks++;
      if (rv) begin
        if (bus.if_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_redirect[%0d]: got v=%b expected v=0", c, bus.if_valid);
        end
        mpc = tgt;
        bubble_seen = 1'b0;
      end else if (st) begin
        if ({bus.if_valid, bus.if_instr, bus.if_imm, bus.if_pc} !== prev) begin
          n_fail++;
          $display("FAIL rand_stall[%0d]: got %h expected %h", c, {bus.if_valid, bus.if_instr, bus.if_imm, bus.if_pc}, prev);
        end
      end else if (bus.if_valid) begin
        ei = mem[mpc[7:0]];
        eimm = (ei[15:11] == IMM_OPC) ? mem[8'(mpc + 32'h1)] : 16'h0;
        if ({bus.if_instr, bus.if_imm, bus.if_pc} !== {ei, eimm, mpc}) begin
          n_fail++;
          $display("FAIL rand_deliver[%0d]: got instr=%h imm=%h pc=%h expected instr=%h imm=%h pc=%h", c, bus.if_instr, bus.if_imm, bus.if_pc, ei, eimm, mpc);
        end
        mpc = mpc + ((ei[15:11] == IMM_OPC) ? 32'h2 : 32'h1);
        bubble_seen = 1'b0;
      end else begin
        ei = mem[mpc[7:0]];
        if (ei[15:11] != IMM_OPC || bubble_seen) begin
          n_fail++;
          $display("FAIL rand_bubble[%0d]: got unexpected bubble at model pc=%h word=%h", c, mpc, ei);
        end
        bubble_seen = 1'b1;
      end
    end
    clear_inputs();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h0;
    mem[8'h01] = 16'h0020;
    mem[8'h20] = {IMM_OPC, 11'h0A0};
    mem[8'h21] = 16'h1234;
    mem[8'h22] = 16'h0800;
    mem[8'h23] = 16'h0801;
    mem[8'h24] = 16'h0802;
    mem[8'h2F] = 16'h0A0F;
    mem[8'h30] = 16'h90A5;
    mem[8'h31] = 16'h5678;
    mem[8'h40] = 16'h0840;
    for (int a = 8'h50; a < 8'h58; a++) mem[a] = 16'h0800 + 16'(a);
    mem[8'hFF] = 16'h0123;
    test_reset();
    test_imm_fetch();
    test_stall();
    test_redirect_imm();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
